// File: rtl/signed_bcd_entry_if.sv
// signed_bcd_entry_if: start/done handshake and data bus for the BCD entry
// converter. The master side requests conversions; the converter is the slave.
interface signed_bcd_entry_if #(
   parameter int DIGITS   = 7,
   parameter int MAG_BITS = 24
);
   logic                  START;
   logic [DIGITS*4-1:0]   BCD_IN;
   logic                  NEG_IN;
   logic                  BUSY;
   logic                  DONE;
   logic                  ERROR;
   logic [MAG_BITS:0]     SIGNED_INT_OUT;

   modport master (
      output START, BCD_IN, NEG_IN,
      input  BUSY, DONE, ERROR, SIGNED_INT_OUT
   );

   modport slave (
      input  START, BCD_IN, NEG_IN,
      output BUSY, DONE, ERROR, SIGNED_INT_OUT
   );
endinterface

// File: rtl/signed_bcd_entry.sv
// signed_bcd_entry: iterative BCD-to-binary converter, one magnitude bit per
// clock (reverse double-dabble). Output is {sign, magnitude}.
// Optional macro NEG_ZERO_CLEAR_EN: when defined, a zero magnitude result
// always carries a cleared sign bit; otherwise the entered sign passes through.
module signed_bcd_entry #(
   parameter int DIGITS   = 7,
   parameter int MAG_BITS = 24
) (
   input  logic              CLK,
   input  logic              RST,
   signed_bcd_entry_if.slave bus
);
   localparam int BCD_BITS = DIGITS * 4;

   typedef enum logic [1:0] {IDLE, CHECK, SHIFT} state_t;

   state_t               state, state_nxt;
   logic [BCD_BITS-1:0]  bcd_q, bcd_shr, bcd_adj;
   logic [MAG_BITS-1:0]  bin_q, bin_shr;
   logic                 sign_q, sign_res;
   logic [4:0]           cnt_q;
   logic                 busy_q, done_q, error_q;
   logic [MAG_BITS:0]    out_q;
   logic [DIGITS-1:0]    dig_bad;
   logic                 bad_digit, last_iter;

   // One right shift of {bcd, bin}; the bcd low bit moves into the bin MSB.
   assign bcd_shr = {1'b0, bcd_q[BCD_BITS-1:1]};
   assign bin_shr = {bcd_q[0], bin_q[MAG_BITS-1:1]};

   // Per-digit correction after the shift, and per-digit range check.
   for (genvar i = 0; i < DIGITS; i++) begin : g_dig
      assign bcd_adj[4*i +: 4] = (bcd_shr[4*i +: 4] >= 4'd8) ? bcd_shr[4*i +: 4] - 4'd3
                                                              : bcd_shr[4*i +: 4];
      assign dig_bad[i] = (bcd_q[4*i +: 4] > 4'd9);
   end

   assign bad_digit = |dig_bad;
   assign last_iter = (cnt_q == 5'(MAG_BITS - 1));

`ifdef NEG_ZERO_CLEAR_EN
   assign sign_res = sign_q & (|bin_shr);
`else
   assign sign_res = sign_q;
`endif

   // State register; reset aborts any conversion in flight.
   always_ff @(posedge CLK) begin
      if (RST) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state decode.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.START) state_nxt = CHECK;
         CHECK:   state_nxt = bad_digit ? IDLE : SHIFT;
         SHIFT:   if (last_iter) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath and handshake registers; DONE defaults low so it is a single pulse.
   always_ff @(posedge CLK) begin
      if (RST) begin
         bcd_q   <= '0;
         bin_q   <= '0;
         sign_q  <= 1'b0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         error_q <= 1'b0;
         out_q   <= '0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.START) begin
                  bcd_q   <= bus.BCD_IN;
                  sign_q  <= bus.NEG_IN;
                  bin_q   <= '0;
                  error_q <= 1'b0;
                  busy_q  <= 1'b1;
               end
            end
            CHECK: begin
               if (bad_digit) begin
                  out_q   <= '0;
                  error_q <= 1'b1;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
               end else begin
                  cnt_q <= '0;
               end
            end
            SHIFT: begin
               bcd_q <= bcd_adj;
               bin_q <= bin_shr;
               if (last_iter) begin
                  out_q  <= {sign_res, bin_shr};
                  done_q <= 1'b1;
                  busy_q <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + 5'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.BUSY           = busy_q;
   assign bus.DONE           = done_q;
   assign bus.ERROR          = error_q;
   assign bus.SIGNED_INT_OUT = out_q;
endmodule

// File: tb/tb_signed_bcd_entry.sv
// tb_signed_bcd_entry: directed vectors for signed_bcd_entry with
// hand-computed results. Honours NEG_ZERO_CLEAR_EN the same way as the design.
module tb_signed_bcd_entry;
   logic CLK = 1'b0;
   logic RST;
   int   n_tests = 0;
   int   n_fail  = 0;

   signed_bcd_entry_if bus ();

   signed_bcd_entry dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   always #5 CLK = ~CLK;

   // Advance to 1 ns past the next rising edge; drive and sample there.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, act, exp);
      end
   endtask

   // Wait for DONE (bounded), counting cycles since the accept edge and BUSY cycles.
   task automatic wait_done(input int start_lat, output int lat, output int busy_n);
      lat    = start_lat;
      busy_n = start_lat;
      while (!bus.DONE && lat < 60) begin
         if (bus.BUSY) busy_n++;
         tick();
         lat++;
      end
   endtask

   task automatic run_conv(input string tag, input logic [27:0] bcd, input logic neg,
                           input logic [24:0] exp_out, input logic exp_err, input int exp_lat);
      int lat, busy_n;
      bus.START  = 1'b1;
      bus.BCD_IN = bcd;
      bus.NEG_IN = neg;
      tick();
      bus.START  = 1'b0;
      bus.BCD_IN = 28'hFFFFFFF;   // inputs may change freely after accept
      bus.NEG_IN = ~neg;
      chk({tag, "_err_clr"}, 32'(bus.ERROR), 32'd0);
      wait_done(0, lat, busy_n);
      chk({tag, "_lat"},  32'(lat),    32'(exp_lat));
      chk({tag, "_busy"}, 32'(busy_n), 32'(exp_lat));
      chk({tag, "_out"},  32'(bus.SIGNED_INT_OUT), 32'(exp_out));
      chk({tag, "_err"},  32'(bus.ERROR), 32'(exp_err));
      chk({tag, "_busy_end"}, 32'(bus.BUSY), 32'd0);
      tick();
      chk({tag, "_done_pulse"}, 32'(bus.DONE), 32'd0);
      chk({tag, "_hold"}, 32'(bus.SIGNED_INT_OUT), 32'(exp_out));
   endtask

   initial begin
      int lat, busy_n, ndone;
      RST        = 1'b1;
      bus.START  = 1'b0;
      bus.BCD_IN = '0;
      bus.NEG_IN = 1'b0;
      tick();
      tick();
      RST = 1'b0;
      chk("rst_busy",  32'(bus.BUSY),  32'd0);
      chk("rst_done",  32'(bus.DONE),  32'd0);
      chk("rst_error", 32'(bus.ERROR), 32'd0);
      chk("rst_out",   32'(bus.SIGNED_INT_OUT), 32'd0);

      run_conv("c12345",  28'h0012345, 1'b0, 25'h0003039, 1'b0, 25);
      run_conv("c9999999", 28'h9999999, 1'b1, 25'h198967F, 1'b0, 25);
      run_conv("badA",    28'h00A0000, 1'b0, 25'h0000000, 1'b1, 1);
      tick();
      chk("err_sticky", 32'(bus.ERROR), 32'd1);
      run_conv("c7",      28'h0000007, 1'b1, 25'h1000007, 1'b0, 25);
      run_conv("badF",    28'hF000000, 1'b1, 25'h0000000, 1'b1, 1);
`ifdef NEG_ZERO_CLEAR_EN
      run_conv("negzero", 28'h0000000, 1'b1, 25'h0000000, 1'b0, 25);
`else
      run_conv("negzero", 28'h0000000, 1'b1, 25'h1000000, 1'b0, 25);
`endif

      // START during BUSY is ignored; START in the DONE cycle is accepted.
      bus.START = 1'b1; bus.BCD_IN = 28'h0000001; bus.NEG_IN = 1'b0;
      tick();
      bus.START = 1'b0;
      repeat (4) tick();
      bus.START = 1'b1; bus.BCD_IN = 28'h0000002;
      tick();
      bus.START = 1'b0;
      wait_done(5, lat, busy_n);
      chk("ign_lat", 32'(lat), 32'd25);
      chk("ign_out", 32'(bus.SIGNED_INT_OUT), 32'h0000001);
      bus.START = 1'b1; bus.BCD_IN = 28'h0000003; bus.NEG_IN = 1'b1;
      tick();
      bus.START = 1'b0;
      chk("b2b_accept", 32'(bus.BUSY), 32'd1);
      wait_done(0, lat, busy_n);
      chk("b2b_lat", 32'(lat), 32'd25);
      chk("b2b_out", 32'(bus.SIGNED_INT_OUT), 32'h1000003);
      tick();

      // Reset mid-conversion: no DONE, outputs cleared, next run correct.
      bus.START = 1'b1; bus.BCD_IN = 28'h0000042; bus.NEG_IN = 1'b0;
      tick();
      bus.START = 1'b0;
      repeat (9) tick();
      RST = 1'b1;
      tick();
      chk("mrst_busy", 32'(bus.BUSY),  32'd0);
      chk("mrst_done", 32'(bus.DONE),  32'd0);
      chk("mrst_err",  32'(bus.ERROR), 32'd0);
      chk("mrst_out",  32'(bus.SIGNED_INT_OUT), 32'd0);
      RST   = 1'b0;
      ndone = 0;
      repeat (30) begin
         tick();
         if (bus.DONE) ndone++;
      end
      chk("mrst_nodone", 32'(ndone), 32'd0);
      run_conv("c42", 28'h0000042, 1'b0, 25'h000002A, 1'b0, 25);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
